knn_dist_calc: RTL and testbench

Distance stage directly upstream of the k-nearest-neighbour list. It latches one test point, then accepts a stream of `NBR_POINTS` dataset points over a valid/ready handshake. For each point it computes the squared Euclidean distance in a 2-stage pipeline. It emits a `valid` / `datap_id` / `dist_entry` triple per point, in the form the list stage consumes.

---
 rtl/knn_dist_calc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_knn_dist_calc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_dist_calc.sv
// -----------------------------------------------------------------------------
// knn_dist_calc
//
// Distance stage feeding the k-nearest-neighbour list. A query begins with
// `start`, which latches the test point. NBR_POINTS dataset points then arrive
// over a valid/ready handshake. Each accepted point is tagged with its
// acceptance index. Its squared Euclidean distance to the test point leaves
// the block as a valid/id/distance triple, three clock edges after acceptance.
//
// Parameters
//   DATA_W      width of dist_entry
//   COORD_W     width of each unsigned coordinate
//   NBR_POINTS  dataset points per query (1..256)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a query and latch test_x/test_y (IDLE only)
//   test_x, test_y    test point coordinates
//   in_valid          dataset point present
//   in_ready          point accepted when in_valid && in_ready
//   in_x, in_y        dataset point coordinates
//   out_valid         one-cycle pulse per result
//   datap_id          acceptance index of the result
//   dist_entry        squared distance (holds when out_valid is low)
//   busy              query in progress (RUN or DRAIN)
//   done              pulses together with the last result of a query
//
// Build option
//   KNN_DIST_SAT_EN   when defined, a sum that does not fit in DATA_W bits
//                     saturates to all ones. That value is the list's
//                     "infinity", so the list never inserts such a point.
//                     When undefined, the low DATA_W bits are kept (wrap).
// -----------------------------------------------------------------------------
module knn_dist_calc #(
    parameter int DATA_W     = 32,
    parameter int COORD_W    = 16,
    parameter int NBR_POINTS = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] test_x,
    input  logic [COORD_W-1:0] test_y,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic [7:0]         datap_id,
    output logic [DATA_W-1:0]  dist_entry,
    output logic               busy,
    output logic               done
);

    localparam int SQ_W  = 2 * COORD_W;
    localparam int SUM_W = 2 * COORD_W + 1;
    localparam int EXT_W = SUM_W + DATA_W;
    localparam logic [7:0] LAST_ID = 8'(NBR_POINTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // |a - b| for unsigned inputs. The difference is formed one bit wider,
    // so its sign is exact. The magnitude always fits back into COORD_W bits.
    function automatic logic [COORD_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] diff;
        logic [COORD_W:0] mag;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[COORD_W]) begin
            mag = (~diff) + {{COORD_W{1'b0}}, 1'b1};
        end else begin
            mag = diff;
        end
        return mag[COORD_W-1:0];
    endfunction

    // Control state
    state_t             state_r;
    logic               in_ready_r;
    logic               busy_r;
    logic [7:0]         id_cnt_r;
    logic [COORD_W-1:0] test_x_r;
    logic [COORD_W-1:0] test_y_r;

    // Stage 1: absolute coordinate differences
    logic               s1_valid_r;
    logic [7:0]         s1_id_r;
    logic [COORD_W-1:0] s1_dx_r;
    logic [COORD_W-1:0] s1_dy_r;

    // Stage 2: squared differences
    logic               s2_valid_r;
    logic [7:0]         s2_id_r;
    logic [SQ_W-1:0]    s2_dx_sq_r;
    logic [SQ_W-1:0]    s2_dy_sq_r;

    // Output registers
    logic               out_valid_r;
    logic [7:0]         datap_id_r;
    logic [DATA_W-1:0]  dist_entry_r;
    logic               done_r;

    // Combinational helpers
    logic               accept_s;
    logic [COORD_W-1:0] dx_s;
    logic [COORD_W-1:0] dy_s;
    logic [SQ_W-1:0]    dx_sq_s;
    logic [SQ_W-1:0]    dy_sq_s;
    logic [SUM_W-1:0]   sum_s;
    logic [EXT_W-1:0]   sum_ext_s;
    logic [DATA_W-1:0]  dist_next_s;
    logic               last_out_s;

    assign accept_s = in_valid && in_ready_r;

    // Stage 1 arithmetic: absolute distance per axis
    always_comb begin
        dx_s = abs_diff(in_x, test_x_r);
        dy_s = abs_diff(in_y, test_y_r);
    end

    // Stage 2 arithmetic: square each axis at full width
    always_comb begin
        dx_sq_s = SQ_W'(s1_dx_r) * SQ_W'(s1_dx_r);
        dy_sq_s = SQ_W'(s1_dy_r) * SQ_W'(s1_dy_r);
    end

    // Output arithmetic: sum the squares, then reduce to DATA_W bits.
    // The sum is zero-extended by DATA_W bits, so the bits above DATA_W
    // form a valid slice for any pair of DATA_W and COORD_W.
    always_comb begin
        sum_s     = {1'b0, s2_dx_sq_r} + {1'b0, s2_dy_sq_r};
        sum_ext_s = {{DATA_W{1'b0}}, sum_s};
`ifdef KNN_DIST_SAT_EN
        if (sum_ext_s[EXT_W-1:DATA_W] != {SUM_W{1'b0}}) begin
            dist_next_s = {DATA_W{1'b1}};
        end else begin
            dist_next_s = sum_ext_s[DATA_W-1:0];
        end
`else
        dist_next_s = sum_ext_s[DATA_W-1:0];
`endif
        last_out_s = s2_valid_r && (s2_id_r == LAST_ID) && (state_r == ST_DRAIN);
    end

`ifndef KNN_DIST_SAT_EN
    // In wrap mode the bits above DATA_W are dropped on purpose.
    logic unused_sum_hi_s;
    assign unused_sum_hi_s = ^sum_ext_s[EXT_W-1:DATA_W];
`endif

    // Query FSM: start latching, id counting, in_ready and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            id_cnt_r   <= 8'd0;
            test_x_r   <= {COORD_W{1'b0}};
            test_y_r   <= {COORD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        test_x_r   <= test_x;
                        test_y_r   <= test_y;
                        id_cnt_r   <= 8'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        id_cnt_r <= id_cnt_r + 8'd1;
                        if (id_cnt_r == LAST_ID) begin
                            in_ready_r <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // done_r is high during the cycle that carries the last
                    // result. Leave at the end of that cycle, so busy stays
                    // high alongside done and drops one cycle later.
                    if (done_r) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Pipeline stage 1 registers: tag the accepted point and register |dx|, |dy|
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 8'd0;
            s1_dx_r    <= {COORD_W{1'b0}};
            s1_dy_r    <= {COORD_W{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_id_r <= id_cnt_r;
                s1_dx_r <= dx_s;
                s1_dy_r <= dy_s;
            end
        end
    end

    // Pipeline stage 2 registers: squared axis distances
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_id_r    <= 8'd0;
            s2_dx_sq_r <= {SQ_W{1'b0}};
            s2_dy_sq_r <= {SQ_W{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_id_r    <= s1_id_r;
                s2_dx_sq_r <= dx_sq_s;
                s2_dy_sq_r <= dy_sq_s;
            end
        end
    end

    // Output registers: the id and distance hold their values across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            datap_id_r   <= 8'd0;
            dist_entry_r <= {DATA_W{1'b0}};
        end else begin
            out_valid_r <= s2_valid_r;
            done_r      <= last_out_s;
            if (s2_valid_r) begin
                datap_id_r   <= s2_id_r;
                dist_entry_r <= dist_next_s;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign out_valid  = out_valid_r;
    assign done       = done_r;
    assign datap_id   = datap_id_r;
    assign dist_entry = dist_entry_r;

endmodule

// File: tb/tb_knn_dist_calc.sv
// -----------------------------------------------------------------------------
// tb_knn_dist_calc
//
// Directed testbench for knn_dist_calc, built with NBR_POINTS = 4. Inputs
// change 1 time unit after each rising edge. Outputs are sampled at the same
// point, so after the edge that accepts a point, that point's result shows up
// on the second following sample.
// -----------------------------------------------------------------------------
module tb_knn_dist_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] test_x;
    logic [15:0] test_y;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        out_valid;
    logic [7:0]  datap_id;
    logic [31:0] dist_entry;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    knn_dist_calc #(
        .DATA_W     (32),
        .COORD_W    (16),
        .NBR_POINTS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .test_x     (test_x),
        .test_y     (test_y),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .datap_id   (datap_id),
        .dist_entry (dist_entry),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] x, input logic [15:0] y);
        start  = 1'b1;
        test_x = x;
        test_y = y;
        tick();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_x = 16'd0; in_y = 16'd0; test_x = 16'd0; test_y = 16'd0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %0h expected 0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0h expected 0", done); end
        checks++; if (datap_id !== 8'd0) begin failures++; $display("FAIL rst_datap_id: got %0h expected 0", datap_id); end
        checks++; if (dist_entry !== 32'd0) begin failures++; $display("FAIL rst_dist_entry: got %0h expected 0", dist_entry); end
        rst = 1'b0;
        in_valid = 1'b1; in_x = 16'd5; in_y = 16'd5;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready c=%0d: got %0h expected 0", c, in_ready); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid c=%0d: got %0h expected 0", c, out_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy c=%0d: got %0h expected 0", c, busy); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] rx [3] = '{16'd3, 16'd6, 16'd3};
        logic [15:0] ry [3] = '{16'd4, 16'd8, 16'd0};
        logic [31:0] ed [3] = '{32'd0, 32'd25, 32'd16};
        do_start(16'd3, 16'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %0h expected 1", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %0h expected 1", in_ready); end
        in_valid = 1'b1; in_x = 16'd0; in_y = 16'd0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %0h expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid: got %0h expected 1", out_valid); end
        checks++; if (datap_id !== 8'd0) begin failures++; $display("FAIL single_id: got %0h expected 0", datap_id); end
        checks++; if (dist_entry !== 32'd25) begin failures++; $display("FAIL single_dist: got %0d expected 25", dist_entry); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_early: got %0h expected 0", done); end
        // Finish the 4-point query with the remaining three points.
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin in_valid = 1'b1; in_x = rx[c]; in_y = ry[c]; end
            else in_valid = 1'b0;
            tick();
            if (c < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_rest_bubble c=%0d: got %0h expected 0", c, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_rest_valid c=%0d: got %0h expected 1", c, out_valid); end
                checks++; if (datap_id !== 8'(c - 1)) begin failures++; $display("FAIL single_rest_id c=%0d: got %0d expected %0d", c, datap_id, c - 1); end
                checks++; if (dist_entry !== ed[c-2]) begin failures++; $display("FAIL single_rest_dist c=%0d: got %0d expected %0d", c, dist_entry, ed[c-2]); end
                checks++; if (done !== (c == 4)) begin failures++; $display("FAIL single_rest_done c=%0d: got %0h expected %0h", c, done, (c == 4)); end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %0h expected 0", busy); end
    endtask

    task automatic test_stream();
        logic [15:0] px [4] = '{16'd10, 16'd13, 16'd7, 16'd0};
        logic [15:0] py [4] = '{16'd10, 16'd14, 16'd6, 16'd10};
        logic [31:0] ed [4] = '{32'd0, 32'd25, 32'd25, 32'd100};
        do_start(16'd10, 16'd10);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin in_valid = 1'b1; in_x = px[c]; in_y = py[c]; end
            else in_valid = 1'b0;
            tick();
            if (c == 2) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready_run: got %0h expected 1", in_ready); end
            end else if (c == 3) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stream_in_ready_drain: got %0h expected 0", in_ready); end
            end
            if (c < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_bubble c=%0d: got %0h expected 0", c, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid c=%0d: got %0h expected 1", c, out_valid); end
                checks++; if (datap_id !== 8'(c - 2)) begin failures++; $display("FAIL stream_id c=%0d: got %0d expected %0d", c, datap_id, c - 2); end
                checks++; if (dist_entry !== ed[c-2]) begin failures++; $display("FAIL stream_dist c=%0d: got %0d expected %0d", c, dist_entry, ed[c-2]); end
                checks++; if (done !== (c == 5)) begin failures++; $display("FAIL stream_done c=%0d: got %0h expected %0h", c, done, (c == 5)); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stream_busy c=%0d: got %0h expected 1", c, busy); end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy_fall: got %0h expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_after: got %0h expected 0", out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL stream_done_after: got %0h expected 0", done); end
    endtask

    task automatic test_overflow();
        logic [15:0] px [4] = '{16'hFFFF, 16'hFFFF, 16'd0, 16'd2};
        logic [15:0] py [4] = '{16'hFFFF, 16'd0, 16'd0, 16'd3};
        logic [31:0] ed [4];
`ifdef KNN_DIST_SAT_EN
        ed[0] = 32'hFFFF_FFFF;
`else
        ed[0] = 32'hFFFC_0002;
`endif
        ed[1] = 32'hFFFE_0001;
        ed[2] = 32'd0;
        ed[3] = 32'd13;
        do_start(16'd0, 16'd0);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin in_valid = 1'b1; in_x = px[c]; in_y = py[c]; end
            else in_valid = 1'b0;
            tick();
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid c=%0d: got %0h expected 1", c, out_valid); end
                checks++; if (dist_entry !== ed[c-2]) begin failures++; $display("FAIL ovf_dist c=%0d: got %0h expected %0h", c, dist_entry, ed[c-2]); end
                checks++; if (datap_id !== 8'(c - 2)) begin failures++; $display("FAIL ovf_id c=%0d: got %0d expected %0d", c, datap_id, c - 2); end
            end
        end
        tick();
    endtask

    task automatic test_gaps();
        logic        vld [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] px  [6] = '{16'd1, 16'd50, 16'd4, 16'd1, 16'd50, 16'd0};
        logic [15:0] py  [6] = '{16'd2, 16'd50, 16'd6, 16'd7, 16'd50, 16'd0};
        logic [31:0] ed  [6] = '{32'd0, 32'd0, 32'd25, 32'd25, 32'd0, 32'd5};
        logic [7:0]  eid [6] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd3};
        int s;
        do_start(16'd1, 16'd2);
        for (int c = 0; c < 8; c++) begin
            if (c < 6) begin in_valid = vld[c]; in_x = px[c]; in_y = py[c]; end
            else in_valid = 1'b0;
            // A start during RUN must not replace the test point.
            if (c == 1) begin start = 1'b1; test_x = 16'd100; test_y = 16'd100; end
            tick();
            start = 1'b0;
            if (c >= 2) begin
                s = c - 2;
                checks++; if (out_valid !== vld[s]) begin failures++; $display("FAIL gap_valid c=%0d: got %0h expected %0h", c, out_valid, vld[s]); end
                checks++; if (datap_id !== eid[s]) begin failures++; $display("FAIL gap_id c=%0d: got %0d expected %0d", c, datap_id, eid[s]); end
                checks++; if (dist_entry !== (vld[s] ? ed[s] : ed[s-1])) begin failures++; $display("FAIL gap_dist c=%0d: got %0d expected %0d", c, dist_entry, (vld[s] ? ed[s] : ed[s-1])); end
                checks++; if (done !== (s == 5)) begin failures++; $display("FAIL gap_done c=%0d: got %0h expected %0h", c, done, (s == 5)); end
            end
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gap_busy_fall: got %0h expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] px [4] = '{16'd5, 16'd0, 16'd0, 16'd0};
        logic [15:0] py [4] = '{16'd0, 16'd1, 16'd2, 16'd3};
        logic [31:0] ed [4] = '{32'd25, 32'd1, 32'd4, 32'd9};
        do_start(16'd0, 16'd0);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_x = 16'(c + 1); in_y = 16'd0;
            tick();
        end
        checks++; if (out_valid !== 1'b1 || dist_entry !== 32'd1) begin failures++; $display("FAIL mid_pre_rst: got valid=%0h dist=%0d expected valid=1 dist=1", out_valid, dist_entry); end
        rst = 1'b1; in_x = 16'd4;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %0h expected 0", out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done: got %0h expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %0h expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready: got %0h expected 0", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_after_valid c=%0d: got %0h expected 0", c, out_valid); end
        end
        in_valid = 1'b0;
        do_start(16'd0, 16'd0);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin in_valid = 1'b1; in_x = px[c]; in_y = py[c]; end
            else in_valid = 1'b0;
            tick();
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL restart_valid c=%0d: got %0h expected 1", c, out_valid); end
                checks++; if (datap_id !== 8'(c - 2)) begin failures++; $display("FAIL restart_id c=%0d: got %0d expected %0d", c, datap_id, c - 2); end
                checks++; if (dist_entry !== ed[c-2]) begin failures++; $display("FAIL restart_dist c=%0d: got %0d expected %0d", c, dist_entry, ed[c-2]); end
                checks++; if (done !== (c == 5)) begin failures++; $display("FAIL restart_done c=%0d: got %0h expected %0h", c, done, (c == 5)); end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
